paint_brush_ctrl: RTL and testbench

//  Paint sequencer between the joystick/button controls and the shared canvas framebuffer.

---
 rtl/paint_brush_ctrl.sv | 103 ++++++++++
 tb/tb_paint_brush_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: cursor/mode keeper that stamps a square brush into the framebuffer via req/gnt
module paint_brush_ctrl #(
   parameter int CANVAS_W = 160,
   parameter int CANVAS_H = 120,
   parameter int COORD_W  = 8,
   parameter int ADDR_W   = 15,
   parameter int COLOR_W  = 3,
   parameter int DEAD_LO  = 400,
   parameter int DEAD_HI  = 624,
   parameter int BG_COLOR = 0
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               move_tick,
   input  logic [9:0]         joy_x,
   input  logic [9:0]         joy_y,
   input  logic               tool_on,
   input  logic               tool_sel,
   input  logic               size_sel,
   input  logic [COLOR_W-1:0] pen_color,
   output logic               fb_req,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_wdata,
   input  logic               fb_gnt,
   output logic [COORD_W-1:0] cur_x,
   output logic [COORD_W-1:0] cur_y,
   output logic               eraser,
   output logic [1:0]         brush_size,
   output logic               busy
);
   typedef enum logic {IDLE, STAMP} state_t;
   state_t state, state_nxt;
   logic [1:0] s_r;
   logic [COLOR_W-1:0] s_color;
   logic signed [2:0] dx, dy, rs, bs;
   logic signed [COORD_W:0] px, py;
   logic [COORD_W-1:0] nx, ny;
   logic on_canvas, adv, last;
   // the cursor never moves during a stamp, so it doubles as the stamp centre
   assign rs = $signed({1'b0, s_r});
   assign bs = $signed({1'b0, brush_size});
   assign px = $signed({1'b0, cur_x}) + $signed({{(COORD_W-2){dx[2]}}, dx});
   assign py = $signed({1'b0, cur_y}) + $signed({{(COORD_W-2){dy[2]}}, dy});
   assign on_canvas = !px[COORD_W] && !py[COORD_W] &&
                      px[COORD_W-1:0] < COORD_W'(CANVAS_W) && py[COORD_W-1:0] < COORD_W'(CANVAS_H);
   assign last = (dx == rs) && (dy == rs);
   assign nx = (joy_x < 10'(DEAD_LO) && cur_x != '0) ? cur_x - 1'b1 :
               (joy_x > 10'(DEAD_HI) && cur_x != COORD_W'(CANVAS_W-1)) ? cur_x + 1'b1 : cur_x;
   assign ny = (joy_y > 10'(DEAD_HI) && cur_y != '0) ? cur_y - 1'b1 :
               (joy_y < 10'(DEAD_LO) && cur_y != COORD_W'(CANVAS_H-1)) ? cur_y + 1'b1 : cur_y;
   // state register
   always_ff @(posedge clk) begin
      state <= clr ? IDLE : state_nxt;
   end
   // next state and write-port outputs; off-canvas offsets burn one cycle without a request
   always_comb begin
      state_nxt = state;
      fb_req    = 1'b0;
      fb_addr   = '0;
      fb_wdata  = '0;
      busy      = 1'b0;
      adv       = 1'b0;
      if (state == IDLE) begin
         state_nxt = (move_tick && tool_on) ? STAMP : IDLE;
      end else begin
         busy      = 1'b1;
         fb_req    = on_canvas;
         fb_addr   = on_canvas ? ADDR_W'(py[COORD_W-1:0]) * ADDR_W'(CANVAS_W) + ADDR_W'(px[COORD_W-1:0]) : '0;
         fb_wdata  = on_canvas ? s_color : '0;
         adv       = !on_canvas || fb_gnt;
         state_nxt = (adv && last) ? IDLE : STAMP;
      end
   end
   // cursor, mode, stamp snapshot and row-major offset walk
   always_ff @(posedge clk) begin
      if (clr) begin
         cur_x      <= COORD_W'(CANVAS_W/2);
         cur_y      <= COORD_W'(CANVAS_H/2);
         eraser     <= 1'b0;
         brush_size <= 2'd0;
         s_r        <= 2'd0;
         s_color    <= '0;
         dx         <= '0;
         dy         <= '0;
      end else begin
         eraser     <= eraser ^ tool_sel;
         brush_size <= size_sel ? (brush_size == 2'd2 ? 2'd0 : brush_size + 2'd1) : brush_size;
         if (state == IDLE && move_tick) begin
            cur_x <= nx;
            cur_y <= ny;
            if (tool_on) begin
               s_r     <= brush_size;
               s_color <= eraser ? COLOR_W'(BG_COLOR) : pen_color;
               dx      <= -bs;
               dy      <= -bs;
            end
         end else if (adv) begin
            dx <= (dx == rs) ? -rs : dx + 3'sd1;
            dy <= (dx == rs) ? dy + 3'sd1 : dy;
         end
      end
   end
endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: directed and randomized checks of paint_brush_ctrl against a pixel-list model
module tb_paint_brush_ctrl;
   localparam int W = 160;
   localparam int H = 120;
   logic clk = 1'b0;
   logic clr, move_tick, tool_on, tool_sel, size_sel, fb_gnt;
   logic [9:0] joy_x, joy_y;
   logic [2:0] pen_color, fb_wdata;
   logic fb_req, eraser, busy;
   logic [14:0] fb_addr;
   logic [7:0] cur_x, cur_y;
   logic [1:0] brush_size;
   int checks = 0, errors = 0;
   int mx, my, mr, me;
   int exp_q[$], got_q[$];
   int stalls = 0, wr_cnt = 0, req_cnt = 0;
   logic p_wait = 1'b0;
   logic [14:0] p_addr;
   logic [2:0] p_data;

   always #5 clk = ~clk;

   paint_brush_ctrl dut (
      .clk(clk), .clr(clr), .move_tick(move_tick), .joy_x(joy_x), .joy_y(joy_y),
      .tool_on(tool_on), .tool_sel(tool_sel), .size_sel(size_sel), .pen_color(pen_color),
      .fb_req(fb_req), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_gnt(fb_gnt),
      .cur_x(cur_x), .cur_y(cur_y), .eraser(eraser), .brush_size(brush_size), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // record completed writes and check the request is held while the grant is withheld
   always @(posedge clk) begin
      if (fb_req) req_cnt++;
      if (!clr && fb_req && fb_gnt) begin
         got_q.push_back(int'({fb_addr, fb_wdata}));
         wr_cnt++;
      end
      if (!clr && fb_req && !fb_gnt) stalls++;
      if (p_wait && !clr) begin
         chk("hold_req", fb_req, 1);
         chk("hold_addr", fb_addr, p_addr);
         chk("hold_data", fb_wdata, p_data);
      end
      p_wait <= !clr && fb_req && !fb_gnt;
      p_addr <= fb_addr;
      p_data <= fb_wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      step();
      clr = 1'b0;
      mx = W/2; my = H/2; mr = 0; me = 0;
      chk("rst_x", cur_x, 80);
      chk("rst_y", cur_y, 60);
      chk("rst_eraser", eraser, 0);
      chk("rst_size", brush_size, 0);
      chk("rst_req", fb_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", fb_addr, 0);
      chk("rst_data", fb_wdata, 0);
   endtask

   task automatic pulse_size();
      size_sel = 1'b1;
      step();
      size_sel = 1'b0;
      mr = (mr + 1) % 3;
      chk("size", brush_size, mr);
   endtask

   task automatic pulse_tool();
      tool_sel = 1'b1;
      step();
      tool_sel = 1'b0;
      me = 1 - me;
      chk("eraser", eraser, me);
   endtask

   // model: move the cursor by the dead-band rules and list every on-canvas pixel of the stamp
   task automatic model_tick();
      if (joy_x < 400 && mx > 0) mx--;
      else if (joy_x > 624 && mx < W-1) mx++;
      if (joy_y > 624 && my > 0) my--;
      else if (joy_y < 400 && my < H-1) my++;
      exp_q.delete();
      if (tool_on)
         for (int y = my - mr; y <= my + mr; y++)
            for (int x = mx - mr; x <= mx + mr; x++)
               if (x >= 0 && x < W && y >= 0 && y < H)
                  exp_q.push_back((y*W + x)*8 + (me ? 0 : int'(pen_color)));
   endtask

   // gmode: 0 grant tied high, 1 random grant, 2 grant withheld on busy cycles 4..7 plus tool pulse
   task automatic do_tick(input int gmode);
      int n, r2, req0;
      model_tick();
      r2 = (2*mr + 1)*(2*mr + 1);
      got_q.delete();
      stalls = 0;
      req0 = req_cnt;
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      chk("cur_x", cur_x, mx);
      chk("cur_y", cur_y, my);
      if (tool_on) begin
         chk("busy_start", busy, 1);
         n = 0;
         while (busy && n < 300) begin
            fb_gnt = gmode == 1 ? ($urandom_range(0, 3) != 0) : gmode == 2 ? !(n >= 4 && n < 8) : 1'b1;
            tool_sel = gmode == 2 && n == 2;
            step();
            n++;
         end
         tool_sel = 1'b0;
         fb_gnt = 1'b1;
         if (gmode == 2) me = 1 - me;
         chk("stamp_done", busy, 0);
         chk("busy_len", n, r2 + stalls);
         chk("wr_count", got_q.size(), exp_q.size());
         foreach (exp_q[i]) if (i < got_q.size()) chk("wr_pixel", got_q[i], exp_q[i]);
      end else begin
         chk("idle_busy", busy, 0);
         chk("idle_noreq", req_cnt - req0, 0);
      end
   endtask

   function automatic logic [9:0] pick_joy();
      int k = $urandom_range(0, 2);
      return k == 0 ? 10'($urandom_range(0, 399)) : k == 1 ? 10'($urandom_range(400, 624)) : 10'($urandom_range(625, 1023));
   endfunction

   initial begin
      int w0, dir_x, dir_y;
      logic [9:0] bvals [4];
      bvals = '{10'd399, 10'd400, 10'd624, 10'd625};
      move_tick = 0; tool_on = 0; tool_sel = 0; size_sel = 0; fb_gnt = 1;
      joy_x = 512; joy_y = 512; pen_color = 0;
      step();
      do_reset();
      // tool off: cursor walks left, then saturates at the right edge
      joy_x = 0;
      w0 = wr_cnt;
      for (int i = 0; i < 3; i++) do_tick(0);
      chk("walk_x", cur_x, 77);
      joy_x = 1023;
      for (int i = 0; i < 83; i++) do_tick(0);
      chk("sat_right", cur_x, 159);
      chk("no_writes", wr_cnt - w0, 0);
      // dead-band boundaries
      joy_y = 512;
      foreach (bvals[i]) begin
         joy_x = bvals[i];
         do_tick(0);
      end
      // single pixel at the centre
      do_reset();
      joy_x = 512; joy_y = 512; tool_on = 1; pen_color = 5;
      do_tick(0);
      chk("centre_addr", got_q.size() > 0 ? got_q[0] : -1, 9680*8 + 5);
      // r = 2 stamp at the top-left corner
      tool_on = 0; joy_x = 0; joy_y = 1023;
      for (int i = 0; i < 85; i++) do_tick(0);
      chk("corner", {cur_x, cur_y}, 0);
      pulse_size();
      pulse_size();
      joy_x = 512; joy_y = 512; tool_on = 1; pen_color = 3;
      do_tick(0);
      // r = 1 interior stamp with a stalled grant and a mid-stamp tool toggle
      do_reset();
      pulse_size();
      pen_color = 6;
      do_tick(2);
      chk("eraser_after", eraser, 1);
      // eraser stamp
      do_tick(0);
      // clr during an r = 2 stamp
      do_reset();
      pulse_size();
      pulse_size();
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
      got_q.delete();
      step();
      step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      mx = W/2; my = H/2; mr = 0; me = 0;
      chk("abort_req", fb_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cur", {cur_x, cur_y}, {8'd80, 8'd60});
      chk("abort_size", brush_size, 0);
      w0 = wr_cnt;
      for (int i = 0; i < 10; i++) step();
      chk("abort_nowr", wr_cnt - w0, 0);
      chk("abort_prior", got_q.size(), 2);
      // randomized episodes
      for (int e = 0; e < 40; e++) begin
         dir_x = $urandom_range(0, 2);
         dir_y = $urandom_range(0, 2);
         tool_on = 0;
         for (int i = $urandom_range(1, 40); i > 0; i--) begin
            joy_x = dir_x == 0 ? 10'($urandom_range(0, 399)) : dir_x == 1 ? pick_joy() : 10'($urandom_range(625, 1023));
            joy_y = dir_y == 0 ? 10'($urandom_range(0, 399)) : dir_y == 1 ? pick_joy() : 10'($urandom_range(625, 1023));
            do_tick(0);
         end
         for (int i = $urandom_range(0, 2); i > 0; i--) pulse_size();
         if ($urandom_range(0, 1) == 1) pulse_tool();
         pen_color = 3'($urandom);
         tool_on = $urandom_range(0, 3) != 0;
         joy_x = pick_joy();
         joy_y = pick_joy();
         do_tick(1);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
